radix3_ifft_bfly: RTL and testbench

- Sequential radix-3 butterfly for the inverse-FFT (IFFT) path.
- Uses the conjugate twiddle W = e^{+j2π/3} = -1/2 + j√3/2, the counterpart of the forward radix-3 twiddle stage.
- Accepts one 3-point block as three serial complex samples over a valid/ready input, computes the unscaled 3-point IDFT, then emits three serial complex results over a valid/ready output.
- Sits in the IFFT datapath between the stage input buffer and the next stage or reorder buffer.

---
 rtl/radix3_ifft_bfly.sv | 158 +++++++++++++++
 tb/tb_radix3_ifft_bfly.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/radix3_ifft_bfly.sv
// Sequential radix-3 IFFT butterfly: collects three complex samples,
// computes the unscaled 3-point IDFT with W = e^{+j2pi/3}, then emits
// the three results in index order over a valid/ready handshake.
module radix3_ifft_bfly #(
  parameter int WIDTH = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH+1:0] out_re,
  output logic signed [WIDTH+1:0] out_im,
  output logic [1:0]              out_idx
);

  localparam int W2 = WIDTH + 2;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CALC    = 2'd1,
    EMIT    = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic [1:0] idx_nxt;

  logic signed [WIDTH-1:0] x_re [3];
  logic signed [WIDTH-1:0] x_im [3];
  logic signed [W2-1:0]    r_re [3];
  logic signed [W2-1:0]    r_im [3];
  logic signed [W2-1:0]    c_re [3];
  logic signed [W2-1:0]    c_im [3];

  logic in_fire, out_fire;

  function automatic logic signed [W2-1:0] sx(input logic signed [WIDTH-1:0] v);
    return {{2{v[WIDTH-1]}}, v};
  endfunction

  // Arithmetic shift right that truncates toward zero (signed divide by 2^n).
  function automatic logic signed [W2-1:0] trz(input logic signed [W2-1:0] v, input int n);
    logic signed [W2-1:0] bias;
    for (int i = 0; i < W2; i++) bias[i] = (i < n);
    if (v[W2-1]) return (v + bias) >>> n;
    return v >>> n;
  endfunction

  // Shift-add approximation of sqrt(3)/2; every term truncated separately,
  // which keeps K odd-symmetric.
  function automatic logic signed [W2-1:0] k_mul(input logic signed [W2-1:0] v);
    return trz(v, 1) + trz(v, 2) + trz(v, 4) + trz(v, 5) + trz(v, 6)
         + trz(v, 8) + trz(v, 9) + trz(v, 11) + trz(v, 12) + trz(v, 14);
  endfunction

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == EMIT);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_ready && out_valid;

  assign out_re = r_re[out_idx];
  assign out_im = r_im[out_idx];

  // Butterfly datapath from the captured samples.
  always_comb begin
    logic signed [W2-1:0] s_re, s_im, d_re, d_im, h_re, h_im, k_re, k_im;
    s_re = sx(x_re[1]) + sx(x_re[2]);
    s_im = sx(x_im[1]) + sx(x_im[2]);
    d_re = sx(x_re[1]) - sx(x_re[2]);
    d_im = sx(x_im[1]) - sx(x_im[2]);
    h_re = sx(x_re[0]) - trz(s_re, 1);
    h_im = sx(x_im[0]) - trz(s_im, 1);
    k_re = k_mul(d_re);
    k_im = k_mul(d_im);
    c_re[0] = sx(x_re[0]) + s_re;
    c_im[0] = sx(x_im[0]) + s_im;
    c_re[1] = h_re - k_im;
    c_im[1] = h_im + k_re;
    c_re[2] = h_re + k_im;
    c_im[2] = h_im - k_re;
  end

  // Next-state, sample counter and output index control.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = out_idx;
    case (state)
      COLLECT: begin
        if (in_fire) begin
          if (cnt == 2'd2) begin
            cnt_nxt   = 2'd0;
            state_nxt = CALC;
          end else begin
            cnt_nxt = cnt + 2'd1;
          end
        end
      end
      CALC: state_nxt = EMIT;
      EMIT: begin
        if (out_fire) begin
          if (out_idx == 2'd2) begin
            idx_nxt   = 2'd0;
            state_nxt = COLLECT;
          end else begin
            idx_nxt = out_idx + 2'd1;
          end
        end
      end
      default: begin
        state_nxt = COLLECT;
        cnt_nxt   = 2'd0;
        idx_nxt   = 2'd0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= COLLECT;
      cnt     <= 2'd0;
      out_idx <= 2'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      out_idx <= idx_nxt;
    end
  end

  // Sample capture during COLLECT and result registering in CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        x_re[i] <= '0;
        x_im[i] <= '0;
        r_re[i] <= '0;
        r_im[i] <= '0;
      end
    end else begin
      if (in_fire && cnt != 2'd3) begin
        x_re[cnt] <= in_re;
        x_im[cnt] <= in_im;
      end
      if (state == CALC) begin
        for (int i = 0; i < 3; i++) begin
          r_re[i] <= c_re[i];
          r_im[i] <= c_im[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_radix3_ifft_bfly.sv
// Directed bench for radix3_ifft_bfly with hand-computed expectations.
module tb_radix3_ifft_bfly;

  localparam int WIDTH = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [WIDTH-1:0] in_re = '0;
  logic signed [WIDTH-1:0] in_im = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic signed [WIDTH+1:0] out_re;
  logic signed [WIDTH+1:0] out_im;
  logic [1:0] out_idx;

  int total = 0;
  int bad = 0;

  radix3_ifft_bfly #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int re, input int im);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_re = WIDTH'(re);
    in_im = WIDTH'(im);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("in_ready_timeout", n, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input int idx, input int re, input int im);
    int n;
    @(negedge clk);
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk({tag, "_timeout"}, n, 0);
    chk({tag, "_idx"}, int'(out_idx), idx);
    chk({tag, "_re"}, int'(out_re), re);
    chk({tag, "_im"}, int'(out_im), im);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic block(input string tag, input int a_re, input int a_im,
                       input int b_re, input int b_im, input int c_re, input int c_im,
                       input int e0r, input int e0i, input int e1r, input int e1i,
                       input int e2r, input int e2i);
    send(a_re, a_im);
    send(b_re, b_im);
    send(c_re, c_im);
    recv({tag, "_x0"}, 0, e0r, e0i);
    recv({tag, "_x1"}, 1, e1r, e1i);
    recv({tag, "_x2"}, 2, e2r, e2i);
  endtask

  initial begin
    // Reset state.
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_re", int'(out_re), 0);
    chk("rst_out_im", int'(out_im), 0);
    rst_n = 1'b1;

    // Impulse on x0, with latency check: CALC cycle, then EMIT.
    send(100, 0);
    send(0, 0);
    send(0, 0);
    chk("lat_calc_valid", int'(out_valid), 0);
    chk("lat_calc_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("lat_emit_valid", int'(out_valid), 1);
    recv("imp_x0", 0, 100, 0);
    recv("imp_x1", 1, 100, 0);
    recv("imp_x2", 2, 100, 0);

    // x1 = 64: K(64) = 55.
    block("p64", 0, 0, 64, 0, 0, 0, 64, 0, -32, 55, -32, -55);
    // x1 = -64: odd symmetry, K(-64) = -55.
    block("n64", 0, 0, -64, 0, 0, 0, -64, 0, 32, -55, 32, 55);

    // x1 = j100 with a 4-cycle output stall on index 1.
    send(0, 0);
    send(0, 100);
    send(0, 0);
    recv("j100_x0", 0, 0, 100);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_idx", int'(out_idx), 1);
      chk("stall_re", int'(out_re), -85);
      chk("stall_im", int'(out_im), -50);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    recv("j100_x1", 1, -85, -50);
    recv("j100_x2", 2, 85, -50);
    @(negedge clk);
    chk("back_to_collect", int'(in_ready), 1);

    // Full scale negative on all inputs.
    block("fs", -16384, -16384, -16384, -16384, -16384, -16384,
          -49152, -49152, 0, 0, 0, 0);

    // Reset mid-block after x1, then a fresh block.
    send(999, 7);
    send(-500, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", int'(in_ready), 1);
    chk("mid_rst_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    // s = 50, d = -10, K(-10) = -5 - 2 = -7.
    send(10, 0);
    send(20, 0);
    chk("no_early_calc", int'(in_ready), 1);
    send(30, 0);
    recv("post_rst_x0", 0, 60, 0);
    recv("post_rst_x1", 1, -15, -7);
    recv("post_rst_x2", 2, -15, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=%0d", total, -1);
    $fatal(1, "timeout");
  end

endmodule
